// File: rtl/case_9_mul_arbiter.sv
`default_nettype none
// ============================================================================
// case_9_mul_arbiter : round-robin arbiter sharing one signed multiplier among
//                      NUM_REQ requesters, with a registered tagged response.
// Option macro       : CASE_9_MUL_ARB_SAT_EN (clamp product instead of wrap)
// Revision           : 1.0
// ============================================================================

module case_9_mul_arbiter_mul #(
    parameter int DIN0_WIDTH = 6,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 12
) (
    input  logic [DIN0_WIDTH-1:0] din0_i,
    input  logic [DIN1_WIDTH-1:0] din1_i,
    output logic [DOUT_WIDTH-1:0] dout_o
);
    logic signed [DOUT_WIDTH-1:0] a_ext;
    logic signed [DOUT_WIDTH-1:0] b_ext;

    // Sign-extend first so the product is computed at full output width.
    assign a_ext  = {{(DOUT_WIDTH-DIN0_WIDTH){din0_i[DIN0_WIDTH-1]}}, din0_i};
    assign b_ext  = {{(DOUT_WIDTH-DIN1_WIDTH){din1_i[DIN1_WIDTH-1]}}, din1_i};
    assign dout_o = a_ext * b_ext;
endmodule

module case_9_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN_WIDTH  = 6,
    parameter int DOUT_WIDTH = 6,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DOUT_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id
);
    localparam int PROD_WIDTH = 2 * DIN_WIDTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic [DOUT_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]      grant;
    logic                    found;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic [ID_WIDTH-1:0]     gnt_nxt;
    logic [DIN_WIDTH-1:0]    op_a;
    logic [DIN_WIDTH-1:0]    op_b;
    logic [PROD_WIDTH-1:0]   prod_full;
    logic [DOUT_WIDTH-1:0]   prod_red;
    logic                    can_issue;
    logic                    xfer;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : p_grant
        int idx;
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        gnt_nxt = '0;
        op_a    = '0;
        op_b    = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx] && !found) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = ID_WIDTH'(idx);
                gnt_nxt    = ID_WIDTH'((idx + 1) % NUM_REQ);
                op_a       = req_a[idx*DIN_WIDTH +: DIN_WIDTH];
                op_b       = req_b[idx*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    assign can_issue = (state_q == ST_EMPTY) || rsp_ready;
    assign req_ready = can_issue ? grant : '0;
    assign xfer      = can_issue && found;

    case_9_mul_arbiter_mul #(
        .DIN0_WIDTH (DIN_WIDTH),
        .DIN1_WIDTH (DIN_WIDTH),
        .DOUT_WIDTH (PROD_WIDTH)
    ) u_mul (
        .din0_i (op_a),
        .din1_i (op_b),
        .dout_o (prod_full)
    );

`ifdef CASE_9_MUL_ARB_SAT_EN
    logic [PROD_WIDTH-DOUT_WIDTH:0] upper;

    // In range exactly when the bits above the result sign all match it.
    assign upper = prod_full[PROD_WIDTH-1:DOUT_WIDTH-1];

    always_comb begin
        if ((&upper) || !(|upper)) begin
            prod_red = prod_full[DOUT_WIDTH-1:0];
        end else if (prod_full[PROD_WIDTH-1]) begin
            prod_red = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        end else begin
            prod_red = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_prod_upper;

    assign unused_prod_upper = ^prod_full[PROD_WIDTH-1:DOUT_WIDTH];
    assign prod_red          = prod_full[DOUT_WIDTH-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer) begin
            state_d    = ST_FULL;
            rsp_data_d = prod_red;
            rsp_id_d   = gnt_idx;
            rr_ptr_d   = gnt_nxt;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
endmodule
`default_nettype wire

// File: tb/tb_case_9_mul_arbiter.sv
`default_nettype none
// ============================================================================
// tb_case_9_mul_arbiter : directed self-checking bench for case_9_mul_arbiter.
// Revision              : 1.0
// ============================================================================
module tb_case_9_mul_arbiter;
    localparam int NR = 4;
    localparam int DW = 6;
    localparam int OW = 6;
    localparam int IW = 2;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_a = '0;
    logic [NR*DW-1:0]   req_b = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [OW-1:0]      rsp_data;
    logic [IW-1:0]      rsp_id;

    int checks = 0;
    int failures = 0;

    case_9_mul_arbiter #(
        .NUM_REQ    (NR),
        .DIN_WIDTH  (DW),
        .DOUT_WIDTH (OW),
        .ID_WIDTH   (IW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic apply_reset;
        tick();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        ap_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 6'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single;
        set_op(2, 6'h03, 6'h3E);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 6'h3A) begin failures++; $display("FAIL single_data: got %h want 3a", rsp_data); end
        checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fairness;
        int o;
        apply_reset();
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 6'h02);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            o = k % NR;
            checks++; if (req_ready !== (4'b0001 << o)) begin failures++; $display("FAIL fair_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << o); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(o)) begin failures++; $display("FAIL fair_id[%0d]: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, o); end
            checks++; if (rsp_data !== OW'((o + 1) * 2)) begin failures++; $display("FAIL fair_data[%0d]: got %h want %h", k, rsp_data, OW'((o + 1) * 2)); end
        end
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL fair_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        set_op(1, 6'h02, 6'h03);
        set_op(3, 6'h3F, 6'h05);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready: got %b want 0010", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 6'h06 || rsp_id !== 2'd1) begin
                failures++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d want v=1 d=06 id=1", k, rsp_valid, rsp_data, rsp_id);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 6'h3B || rsp_id !== 2'd3) begin
            failures++; $display("FAIL bp_release_rsp: got v=%b d=%h id=%0d want v=1 d=3b id=3", rsp_valid, rsp_data, rsp_id);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_overflow;
        logic [DW-1:0] ta [4] = '{6'h07, 6'h20, 6'h20, 6'h3C};
        logic [DW-1:0] tb [4] = '{6'h07, 6'h20, 6'h01, 6'h05};
`ifdef CASE_9_MUL_ARB_SAT_EN
        logic [OW-1:0] te [4] = '{6'h1F, 6'h1F, 6'h20, 6'h2C};
`else
        logic [OW-1:0] te [4] = '{6'h31, 6'h00, 6'h20, 6'h2C};
`endif
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(0, ta[k], tb[k]);
            req_valid = 4'b0001;
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== te[k]) begin
                failures++; $display("FAIL ovf[%0d]: got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, te[k]);
            end
            req_valid = '0;
            tick();
        end
    endtask

    task automatic test_reset_midflight;
        set_op(2, 6'h02, 6'h02);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_full: got %b want 1", rsp_valid); end
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 6'h00) begin
            failures++; $display("FAIL mid_async_clear: got v=%b d=%h want v=0 d=00", rsp_valid, rsp_data);
        end
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 6'h01);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        tick();
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL mid_first_id: got %0d want 0", rsp_id); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_skip_idle;
        set_op(3, 6'h03, 6'h03);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL skip_ready: got %b want 1000", req_ready); end
        tick();
        checks++; if (rsp_id !== 2'd3 || rsp_data !== 6'h09) begin
            failures++; $display("FAIL skip_rsp: got id=%0d d=%h want id=3 d=09", rsp_id, rsp_data);
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL skip_wrap_ptr: got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_reset_midflight();
        test_skip_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/case_9_mul_arbiter.md
# case_9_mul_arbiter

Round-robin arbiter and sequencer that shares one signed multiplier among NUM_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle, multiplies through a single `case_9_mul_6s_6s_6_1_1`-style combinational multiplier instance, and returns the product on one registered response channel tagged with the requester index. It sits between the case_9 datapath lanes and the shared multiplier resource, replacing per-lane multipliers.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DIN_WIDTH, 6, signed operand width
- DOUT_WIDTH, 6, signed result width
- ID_WIDTH, 2, response tag width; must satisfy 2^ID_WIDTH >= NUM_REQ
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*DIN_WIDTH  packed signed operand A; requester i occupies slice [i*DIN_WIDTH +: DIN_WIDTH]
- req_b  in  NUM_REQ*DIN_WIDTH  packed signed operand B; same packing as req_a
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  downstream accepts the response
- rsp_data  out  DOUT_WIDTH  signed product
- rsp_id  out  ID_WIDTH  index of the requester that produced rsp_data

## Operation
- Output stage is a 2-state machine.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1; rsp_data and rsp_id are held stable.
- can_issue = EMPTY, or (FULL and rsp_ready).
- Grant, when can_issue is true:
  - Choose the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[i]=1 for that i only; all other req_ready bits are 0.
  - When can_issue is false, req_ready is all zero.
- A transfer happens when req_valid[i] & req_ready[i] on a clock edge. On that edge:
  - The product of requester i's operands is captured into rsp_data.
  - rsp_id is set to i and the state becomes FULL.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- FULL with rsp_ready=1 and no transfer: the state becomes EMPTY.
- Simultaneous drain and grant (FULL, rsp_ready=1, transfer): the state stays FULL with the new result. This sustains one result per cycle.
- rr_ptr does not change when there is no transfer.
- Arithmetic:
  - The multiplier instance is configured din0/din1 = DIN_WIDTH and dout = 2*DIN_WIDTH, so the full product is exact.
  - It is then reduced to DOUT_WIDTH per Configuration.
- Requesters must hold req_a/req_b stable while req_valid=1 and req_ready=0. The block does not check this.
- Path req_valid -> req_ready is combinational. req_ready does not depend on req_a/req_b.

## Timing
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, state=EMPTY, rr_ptr=0.
  - req_ready follows the grant logic: it can be nonzero during reset release only if req_valid is set.
- Latency: an operand accepted at edge t produces rsp_valid=1 after edge t (visible in cycle t+1).
- Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0 and state FULL, no requester is granted. Outputs are frozen until drain.
- Reset asserted mid-operation: a pending result is discarded immediately (asynchronous clear), and rr_ptr returns to 0.
- Wrap-around: rr_ptr=NUM_REQ-1 with a grant to NUM_REQ-1 sets rr_ptr to 0.

## Configuration
- CASE_9_MUL_ARB_SAT_EN undefined: rsp_data = low DOUT_WIDTH bits of the full product (two's-complement wrap, same as the standalone HLS multiplier).
- CASE_9_MUL_ARB_SAT_EN defined: the full product is clamped.
  - Results above 2^(DOUT_WIDTH-1)-1 give the maximum (31 at defaults).
  - Results below -2^(DOUT_WIDTH-1) give the minimum (-32 at defaults).
  - In-range products pass unchanged.

## Test plan
- Single request, defaults: requester 2 offers a=3, b=-2, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=6'h3A (-6), rsp_id=2; next cycle rsp_valid=0.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1; one result per cycle; rsp_id sequence matches.
- Backpressure: hold rsp_ready=0 for 5 cycles with requesters 1 and 3 valid -> exactly one transfer, req_ready=0 for 5 cycles, rsp_data stable; on release the next grant goes to 3 the same cycle.
- Overflow: a=7, b=7 -> without macro rsp_data=6'h31 (-15); with CASE_9_MUL_ARB_SAT_EN rsp_data=31. a=-32, b=-32 -> 0 without the macro, 31 with it. a=-32, b=1 -> -32 in both builds.
- Reset mid-flight: deassert ap_rst_n asynchronously while FULL -> rsp_valid drops without waiting for a clock edge; after release, the first grant with all requesters valid goes to requester 0.
- Skip-idle: only requester 3 valid, rr_ptr=1 -> requester 3 is granted immediately and rr_ptr becomes 0.
